// File: rtl/minhash_topk_selector.sv
// minhash_topk_selector
// Bottom-2 MinHash selector: watches one hash per k-mer position of a fragment,
// keeps the two smallest hashes with their positions, and holds the pair for
// the extender until it is accepted.

module minhash_topk_selector #(
  parameter int HASH_W  = 32,
  parameter int IDX_W   = 5,
  parameter int MAX_POS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HASH_W-1:0] in_hash,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HASH_W-1:0] out_hash0,
  output logic [IDX_W-1:0]  out_idx0,
  output logic [HASH_W-1:0] out_hash1,
  output logic [IDX_W-1:0]  out_idx1,
  output logic [1:0]        out_count,
  output logic              out_ovf
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [IDX_W:0] MAX_POS_C = (IDX_W+1)'(MAX_POS);

  state_t            state;
  state_t            state_next;

  logic [HASH_W-1:0] m0;
  logic [HASH_W-1:0] m1;
  logic [IDX_W-1:0]  i0;
  logic [IDX_W-1:0]  i1;
  logic [1:0]        cnt;
  logic [IDX_W:0]    pos;
  logic              ovf;

  logic              accept;
  logic              eligible;
  logic              release_result;
  logic [1:0]        cnt_inc;

  assign accept         = in_valid && (state == ACCUM);
  assign eligible       = (pos < MAX_POS_C);
  assign release_result = (state == HOLD) && out_ready;
  assign cnt_inc        = (cnt == 2'd2) ? 2'd2 : cnt + 2'd1;

  assign out_hash0 = m0;
  assign out_idx0  = i0;
  assign out_hash1 = m1;
  assign out_idx1  = i1;
  assign out_count = cnt;
  assign out_ovf   = ovf;

  // State register: a pending result is dropped outright on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Next state: the last beat closes the fragment, extender acceptance reopens.
  always_comb begin
    state_next = state;
    case (state)
      ACCUM: if (accept && in_last) state_next = HOLD;
      HOLD:  if (out_ready)         state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Handshake outputs depend only on state, so no input-to-output comb path exists.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: in_ready  = 1'b1;
      HOLD:  out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Slot tracking: strict less-than keeps the earlier position on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0  <= '1;
      m1  <= '1;
      i0  <= '0;
      i1  <= '0;
      cnt <= 2'd0;
      pos <= '0;
      ovf <= 1'b0;
    end else if (release_result) begin
      m0  <= '1;
      m1  <= '1;
      i0  <= '0;
      i1  <= '0;
      cnt <= 2'd0;
      pos <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      if (pos != '1) begin
        pos <= pos + 1'b1;
      end
      if (!eligible) begin
        ovf <= 1'b1;
      end else if ((cnt == 2'd0) || (in_hash < m0)) begin
        if (cnt != 2'd0) begin
          m1 <= m0;
          i1 <= i0;
        end
        m0  <= in_hash;
        i0  <= pos[IDX_W-1:0];
        cnt <= cnt_inc;
      end else if ((cnt < 2'd2) || (in_hash < m1)) begin
        m1  <= in_hash;
        i1  <= pos[IDX_W-1:0];
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_minhash_topk_selector.sv
// tb_minhash_topk_selector
// Directed bench for the bottom-2 MinHash selector with hand-computed results.

module tb_minhash_topk_selector;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_hash;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_hash0;
  logic [4:0]  out_idx0;
  logic [31:0] out_hash1;
  logic [4:0]  out_idx1;
  logic [1:0]  out_count;
  logic        out_ovf;

  int checks;
  int errors;

  minhash_topk_selector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_hash   (in_hash),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hash0 (out_hash0),
    .out_idx0  (out_idx0),
    .out_hash1 (out_hash1),
    .out_idx1  (out_idx1),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one beat and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [31:0] h, input logic last);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    in_hash  = h;
    in_last  = last;
    while (!in_ready && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready) checkOutput("beat_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Compares the whole result bundle against hand-computed values.
  task automatic checkResult(input string name, input logic [31:0] h0, input logic [31:0] x0,
                             input logic [31:0] h1, input logic [31:0] x1,
                             input logic [31:0] c, input logic [31:0] o);
    checkOutput({name, ".valid"}, 32'(out_valid), 32'd1);
    checkOutput({name, ".hash0"}, out_hash0, h0);
    checkOutput({name, ".idx0"},  32'(out_idx0), x0);
    checkOutput({name, ".hash1"}, out_hash1, h1);
    checkOutput({name, ".idx1"},  32'(out_idx1), x1);
    checkOutput({name, ".count"}, 32'(out_count), c);
    checkOutput({name, ".ovf"},   32'(out_ovf), o);
  endtask

  // Hands the result to the extender for one cycle and checks the return to ACCUM.
  task automatic takeResult(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({name, ".released_valid"}, 32'(out_valid), 32'd0);
    checkOutput({name, ".released_ready"}, 32'(in_ready), 32'd1);
  endtask

  // Checks every output against its reset value.
  task automatic checkIdle(input string name);
    checkOutput({name, ".valid"}, 32'(out_valid), 32'd0);
    checkOutput({name, ".ready"}, 32'(in_ready), 32'd1);
    checkOutput({name, ".hash0"}, out_hash0, 32'hFFFF_FFFF);
    checkOutput({name, ".idx0"},  32'(out_idx0), 32'd0);
    checkOutput({name, ".hash1"}, out_hash1, 32'hFFFF_FFFF);
    checkOutput({name, ".idx1"},  32'(out_idx1), 32'd0);
    checkOutput({name, ".count"}, 32'(out_count), 32'd0);
    checkOutput({name, ".ovf"},   32'(out_ovf), 32'd0);
  endtask

  // Main directed sequence.
  initial begin
    logic [31:0] vec5 [5];
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_hash   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    vec5      = '{32'd50, 32'd20, 32'd70, 32'd10, 32'd30};

    #23;
    checkIdle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Five-beat fragment: 10@3 and 20@1 win.
    for (int i = 0; i < 5; i++) applyStimulus(vec5[i], (i == 4));
    checkResult("basic", 32'd10, 32'd3, 32'd20, 32'd1, 32'd2, 32'd0);
    checkOutput("basic.in_ready_low", 32'(in_ready), 32'd0);
    takeResult("basic");

    // Equal hashes never displace: positions 0 and 1 survive.
    for (int i = 0; i < 3; i++) applyStimulus(32'd5, (i == 2));
    checkResult("ties", 32'd5, 32'd0, 32'd5, 32'd1, 32'd2, 32'd0);
    takeResult("ties");

    // Single-beat fragment leaves slot1 at its empty value.
    applyStimulus(32'h1234, 1'b1);
    checkResult("single", 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0);
    takeResult("single");

    // Exactly 32 beats, descending hashes: no overflow.
    for (int p = 0; p < 32; p++) applyStimulus(32'(100 - p), (p == 31));
    checkResult("full32", 32'd69, 32'd31, 32'd70, 32'd30, 32'd2, 32'd0);
    takeResult("full32");

    // 33 beats: position 32 (hash 68) is ignored and flags overflow.
    for (int p = 0; p < 33; p++) applyStimulus(32'(100 - p), (p == 32));
    checkResult("ovf33", 32'd69, 32'd31, 32'd70, 32'd30, 32'd2, 32'd1);
    takeResult("ovf33");
    checkOutput("ovf33.cleared_ovf", 32'(out_ovf), 32'd0);

    // Backpressure: result 3@1 / 7@0 must hold while beats are offered.
    applyStimulus(32'd7, 1'b0);
    applyStimulus(32'd3, 1'b1);
    in_valid = 1'b1;
    in_hash  = 32'd1;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp.in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp.hash0", out_hash0, 32'd3);
      checkOutput("bp.idx0", 32'(out_idx0), 32'd1);
      checkOutput("bp.hash1", out_hash1, 32'd7);
      @(posedge clk); #1;
    end
    checkResult("bp", 32'd3, 32'd1, 32'd7, 32'd0, 32'd2, 32'd0);
    in_hash   = 32'd40;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp.release_ready", 32'(in_ready), 32'd1);
    checkOutput("bp.release_count", 32'(out_count), 32'd0);
    @(posedge clk); #1;
    checkOutput("bp.first_beat_taken", 32'(out_count), 32'd1);
    in_hash = 32'd60;
    in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkResult("bp_next", 32'd40, 32'd0, 32'd60, 32'd1, 32'd2, 32'd0);
    takeResult("bp_next");

    // Asynchronous reset mid-fragment wipes the partial state between edges.
    applyStimulus(32'd11, 1'b0);
    applyStimulus(32'd12, 1'b0);
    applyStimulus(32'd13, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkIdle("async_rst");
    #4;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(32'd9, 1'b0);
    applyStimulus(32'd4, 1'b1);
    checkResult("post_rst", 32'd4, 32'd1, 32'd9, 32'd0, 32'd2, 32'd0);
    takeResult("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
